regfile_write_port: RTL

- Write side of the 8 x 16-bit register file. The 8:1 bitwise read multiplexers select from this block's register outputs.
- Accepts write-back requests from the pipeline and holds each one in a one-entry write-back stage.
- Decodes the 3-bit destination to a one-hot enable and commits the data into one of eight 16-bit registers.
- Exposes all eight registers as a flat bus that feeds the read-port muxes.

---
 rtl/regfile_write_port.sv | 91 +++++++++
 1 files changed

// File: rtl/regfile_write_port.sv
// Write side of an 8 x 16-bit register file: one-entry write-back stage, one-hot commit, flat read bus.
// Optional macro REGFILE_BYPASS_EN forwards the pending write onto its regs_flat slice.
module regfile_write_port #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [2:0]             wr_sel,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   hold,
    output logic                   wr_ready,
    output logic                   pend_valid,
    output logic [2:0]             pend_sel,
    output logic [NREGS*WIDTH-1:0] regs_flat,
    output logic [CNT_W-1:0]       commit_cnt
);

    function automatic logic [NREGS-1:0] decode_onehot(input logic [2:0] sel);
        logic [NREGS-1:0] d;
        d      = '0;
        d[sel] = 1'b1;
        return d;
    endfunction

    logic                   r_vld_p1;
    logic [2:0]             r_sel_p1;
    logic [WIDTH-1:0]       r_data_p1;
    logic [WIDTH-1:0]       r_regs [NREGS];
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_accept;
    logic                   w_commit;
    logic [NREGS-1:0]       w_wen;

    assign wr_ready   = !r_vld_p1 || !hold;
    assign w_accept   = wr_en && wr_ready;
    assign w_commit   = r_vld_p1 && !hold;
    assign w_wen      = w_commit ? decode_onehot(r_sel_p1) : '0;

    assign pend_valid = r_vld_p1;
    assign pend_sel   = r_sel_p1;
    assign commit_cnt = r_cnt;

    // Stage p1: write-back holding register; commit into the register array
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_sel_p1  <= '0;
            r_data_p1 <= '0;
            r_cnt     <= '0;
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_vld_p1  <= 1'b1;
                r_sel_p1  <= wr_sel;
                r_data_p1 <= wr_data;
            end else if (w_commit) begin
                r_vld_p1  <= 1'b0;
            end
            if (w_commit) begin
                r_cnt <= r_cnt + 1'b1;
            end
            for (int k = 0; k < NREGS; k++) begin
                if (w_wen[k]) begin
                    r_regs[k] <= r_data_p1;
                end
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int k = 0; k < NREGS; k++) begin
`ifdef REGFILE_BYPASS_EN
            if (r_vld_p1 && (int'(r_sel_p1) == k)) begin
                regs_flat[k*WIDTH +: WIDTH] = r_data_p1;
            end else begin
                regs_flat[k*WIDTH +: WIDTH] = r_regs[k];
            end
`else
            regs_flat[k*WIDTH +: WIDTH] = r_regs[k];
`endif
        end
    end

endmodule
